// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: width math and the
// elaboration-time KMP next-state function.
package seq_det_pkg;

  localparam int MAX_LEN = 32;
  localparam int STATE_W = 5;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_MATCH,
    ACT_CLEAR
  } act_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // History is the first k pattern bits followed by b; the result is the longest
  // prefix of the pattern (shorter than len) that ends that history.
  function automatic logic [STATE_W-1:0] seq_det_next(
    input logic [MAX_LEN-1:0] pattern,
    input int                 len,
    input int                 k,
    input logic               b
  );
    logic [MAX_LEN-1:0] hist;
    int                 best;
    logic               ok;
    hist = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < k) hist[i] = pattern[len-1-i];
      else if (i == k) hist[i] = b;
    end
    best = 0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= k + 1 && j <= len - 1) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_LEN; t++) begin
          if (t < j) begin
            if (hist[k+1-j+t] != pattern[len-1-t]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return STATE_W'(best);
  endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// Saturating match tally with synchronous clear; sticks at all-ones.
module seq_det_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Bit-serial detector for a compile-time pattern with runtime overlap select;
// registered one-cycle match pulse plus saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = LEN'(4'b1011),
  parameter int             CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in,
  input  logic                   valid,
  input  logic                   overlap,
  input  logic                   clear,
  output logic                   out,
  output logic [clog2(LEN)-1:0]  state,
  output logic [CNT_W-1:0]       count
);

  localparam int SW = clog2(LEN);
  localparam int NS = 1 << SW;

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];
  logic [SW-1:0] st_q;
  logic [SW-1:0] st_d;
  logic [SW-1:0] tbl_nxt;
  logic          out_d;
  logic          inc;
  act_e          act;

  // Unreachable encodings (when LEN is not a power of two) fall back to 0.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k < LEN) begin : g_live
      assign nxt0[k] = SW'(seq_det_next(MAX_LEN'(PATTERN), LEN, k, 1'b0));
      assign nxt1[k] = SW'(seq_det_next(MAX_LEN'(PATTERN), LEN, k, 1'b1));
    end else begin : g_dead
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  always_comb begin
    act     = ACT_HOLD;
    st_d    = st_q;
    out_d   = 1'b0;
    inc     = 1'b0;
    tbl_nxt = in ? nxt1[st_q] : nxt0[st_q];
    if (clear) begin
      act = ACT_CLEAR;
    end else if (valid) begin
      act = ((st_q == SW'(LEN - 1)) && (in == PATTERN[0])) ? ACT_MATCH : ACT_STEP;
    end
    case (act)
      ACT_CLEAR: st_d = '0;
      ACT_STEP:  st_d = tbl_nxt;
      ACT_MATCH: begin
        out_d = 1'b1;
        inc   = 1'b1;
        st_d  = overlap ? tbl_nxt : '0;
      end
      default:   st_d = st_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '0;
      out  <= 1'b0;
    end else begin
      st_q <= st_d;
      out  <= out_d;
    end
  end

  assign state = st_q;

  seq_det_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (inc),
    .count (count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Two detector instances (1011 / 8-bit count, 1111 / 2-bit count) on shared
// inputs, compared each cycle against a history-based reference model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in = 1'b0;
  logic valid = 1'b0;
  logic overlap = 1'b0;
  logic clear = 1'b0;

  logic       out_a, out_b;
  logic [1:0] state_a, state_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  always #5 clk = ~clk;

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in(in), .valid(valid), .overlap(overlap),
    .clear(clear), .out(out_a), .state(state_a), .count(count_a)
  );

  seq_detector_param #(.LEN(4), .PATTERN(4'b1111), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in(in), .valid(valid), .overlap(overlap),
    .clear(clear), .out(out_b), .state(state_b), .count(count_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference: received bits since the last restart, newest at bit 0.
  logic [3:0]  pat  [2] = '{4'b1011, 4'b1111};
  int          cmax [2] = '{255, 3};
  logic [31:0] hb   [2] = '{32'd0, 32'd0};
  int          hl   [2] = '{0, 0};
  int          eo   [2] = '{0, 0};
  int          ec   [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Longest pattern prefix (shorter than the pattern) that ends the history.
  function automatic int mstate(input int i);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < 4; k++) begin
      if (k <= hl[i]) begin
        ok = 1'b1;
        for (int t = 0; t < k; t++)
          if (hb[i][k-1-t] !== pat[i][3-t]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset || clear) begin
        hb[i] = '0; hl[i] = 0; eo[i] = 0; ec[i] = 0;
      end else if (valid) begin
        hb[i] = {hb[i][30:0], in};
        if (hl[i] < 32) hl[i]++;
        eo[i] = 0;
        if (hl[i] >= 4 && hb[i][3:0] == pat[i]) begin
          eo[i] = 1;
          if (ec[i] < cmax[i]) ec[i]++;
          if (!overlap) begin
            hb[i] = '0; hl[i] = 0;
          end
        end
      end else begin
        eo[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("a_out",   32'(out_a),   32'(eo[0]));
    chk("a_state", 32'(state_a), 32'(mstate(0)));
    chk("a_count", 32'(count_a), 32'(ec[0]));
    chk("b_out",   32'(out_b),   32'(eo[1]));
    chk("b_state", 32'(state_b), 32'(mstate(1)));
    chk("b_count", 32'(count_b), 32'(ec[1]));
  endtask

  task automatic cyc(input logic b, input logic v, input logic ov, input logic cl);
    in = b; valid = v; overlap = ov; clear = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [31:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1, ov, 1'b0);
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_state", 32'(state_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    reset = 1'b0;

    // Overlapping 1011011: pulses after bits 4 and 7
    send(32'b1011, 4, 1'b1);
    chk("t1_pulse4", 32'(out_a), 32'd1);
    send(32'b011, 3, 1'b1);
    chk("t1_pulse7", 32'(out_a), 32'd1);
    chk("t1_count", 32'(count_a), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Non-overlapping: single match, state 1 at the end
    send(32'b1011011, 7, 1'b0);
    chk("t2_count", 32'(count_a), 32'd1);
    chk("t2_state", 32'(state_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Valid gap holds the prefix
    send(32'b101, 3, 1'b1);
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_hold", 32'(state_a), 32'd3);
      chk("t3_nopulse", 32'(out_a), 32'd0);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_pulse", 32'(out_a), 32'd1);
    chk("t3_count", 32'(count_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-pattern
    send(32'b101, 3, 1'b1);
    chk("t4_pre", 32'(state_a), 32'd3);
    valid = 1'b0;
    @(posedge clk);
    model_edge();
    #2 reset = 1'b1;
    #1;
    model_edge();
    chk("t4_async_state", 32'(state_a), 32'd0);
    chk("t4_async_out", 32'(out_a), 32'd0);
    chk("t4_async_count", 32'(count_a), 32'd0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    send(32'b1011, 4, 1'b1);
    chk("t4_count", 32'(count_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // 1111 with a 2-bit counter: four pulses, saturates at 3
    send(32'b1111111, 7, 1'b1);
    chk("t5_pulse", 32'(out_b), 32'd1);
    chk("t5_sat", 32'(count_b), 32'd3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Clear on the completing bit wins
    send(32'b101, 3, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_out", 32'(out_a), 32'd0);
    chk("t6_count", 32'(count_a), 32'd0);
    chk("t6_state", 32'(state_a), 32'd0);

    // Random traffic with runtime overlap changes and occasional clears
    repeat (400) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the next generation of the single-pattern bit-serial FSM. It detects a compile-time pattern of configurable length on a 1-bit input stream, qualified by a valid strobe. Overlap versus non-overlap matching is selected at runtime. It also keeps a saturating count of matches. It sits directly on a serial input line and feeds a one-cycle match pulse and a match tally to downstream control logic.

## Interface
- `LEN`, 4: pattern length in bits, 2..32.
- `PATTERN`, 4'b1011: `LEN`-bit pattern; `PATTERN[LEN-1]` is the first bit expected on the line.
- `CNT_W`, 8: width of the match counter.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in` input 1: serial data bit, sampled when `valid` is 1.
- `valid` input 1: qualifies `in`; when 0 the FSM holds.
- `overlap` input 1: 1 = overlapping matches allowed; 0 = after a match, restart from empty.
- `clear` input 1: synchronous clear of state, `out` and `count`.
- `out` output 1: registered match pulse.
- `state` output clog2(LEN): matched-prefix length 0..LEN-1, exposed for debug.
- `count` output CNT_W: number of matches since reset or clear; saturates.

## Operation
- FSM state k (0..LEN-1) = number of leading pattern bits currently matched.
- Transitions use a KMP-style table computed at elaboration from `PATTERN`:
  - On a valid bit equal to expected bit `PATTERN[LEN-1-k]`, k→k+1.
  - On a mismatch, k→ the longest proper prefix that is a suffix of the received history plus this bit. This may be 0 or nonzero, e.g. for 1011, state 1 on input 1 stays at 1.
- Completion (k = LEN-1 and correct bit):
  - `out` is 1 next cycle.
  - `count` increments unless already all-ones.
  - State goes to fail(LEN) if `overlap`=1, else 0.
  - `overlap` is sampled on the same edge as the completing bit.
- `valid`=0: state and `count` hold; `out` is 0 next cycle.
- `clear`=1 takes priority over `valid`: state 0, `out` 0, `count` 0 next edge; the concurrent bit is discarded.
- Reset values: `state` 0, `out` 0, `count` 0.
- Reset asserted mid-pattern discards the partial match. The first valid bit after release is treated as bit 0 of a new stream.
- `count` saturates at 2^CNT_W-1; further matches still pulse `out`.

## Timing
- Latency is 1 cycle: the completing bit is sampled at edge N and `out`=1 during cycle N..N+1 (registered Moore-style output). No combinational path from `in` to `out`.
- Back-to-back matches (overlap, e.g. pattern 1111 with a run of ones) give consecutive `out` pulses, one per completing bit.
- `count` updates on the same edge that sets `out`.
- Reset deassertion is synchronous to `clk` at the system level; the block places no recovery-cycle requirement beyond standard flop timing.

## Structure
- Package `seq_det_pkg` contains:
  - the `clog2` function;
  - the elaboration-time function `seq_det_next(pattern, len, k, bit)` that returns the next state;
  - the localparam `STATE_W`.
- Sub-module `seq_det_match_counter`: `CNT_W` saturating counter with synchronous clear and increment enable. The top module holds the FSM and the output register.

## Test plan
- LEN=4, PATTERN=1011, overlap=1, valid=1, stream 1,0,1,1,0,1,1 → `out` pulses after bits 4 and 7; `count`=2.
- Same stream with overlap=0 → single pulse after bit 4; `count`=1; `state`=1 after bit 7.
- Stream 1,0,1 then valid=0 for 3 cycles then bit 1 → state holds at 3 during the gap, `out` pulses once after the final bit, `count`=1.
- Reset asserted after 1,0,1 (state 3), asynchronously between edges → `state`/`out`/`count` go to 0 immediately; the next 1,0,1,1 gives exactly one match.
- CNT_W=2, pattern 1111, overlap=1, seven ones → pulses after bits 4,5,6,7; `count` saturates at 3.
- `clear` asserted on the cycle the completing bit arrives → no `out` pulse, `count`=0, `state`=0.
